// File: rtl/fir_pkg.sv
// Shared types and elaboration-time helpers for the time-multiplexed FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Headroom of clog2(taps) bits guarantees the sum of all products never overflows.
  function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
    return data_w + coeff_w + clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate with clear/enable and the output scaling stage.
// FIR_ROUND_SAT_EN selects half-up rounding with saturation instead of truncate-and-wrap.
module fir_mac_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int ACC_WIDTH   = 18,
  parameter int OUT_WIDTH   = 8,
  parameter int OUT_SHIFT   = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [DATA_WIDTH-1:0]  x,
  input  logic [COEFF_WIDTH-1:0] c,
  output logic [OUT_WIDTH-1:0]   y
);

  localparam int PW  = DATA_WIDTH + COEFF_WIDTH;
  localparam int PAD = ACC_WIDTH - PW;

  logic signed [PW-1:0]        prod_s;
  logic signed [ACC_WIDTH-1:0] acc_r;
  logic signed [ACC_WIDTH:0]   ext_s;
  logic signed [ACC_WIDTH:0]   shifted_s;

  // Full-precision signed product of the current tap.
  always_comb begin
    prod_s = $signed(x) * $signed(c);
  end

  // Accumulator: clear wins over enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + {{PAD{prod_s[PW-1]}}, prod_s};
    end
  end

`ifdef FIR_ROUND_SAT_EN
  localparam int RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [ACC_WIDTH:0] ONE = (ACC_WIDTH + 1)'(1);
  localparam logic signed [ACC_WIDTH:0] RND = (OUT_SHIFT > 0) ? (ONE <<< RND_POS) : '0;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH + 1)'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = -SAT_MAX - ONE;

  // One guard bit keeps the rounding increment from wrapping.
  always_comb begin
    ext_s     = {acc_r[ACC_WIDTH-1], acc_r};
    shifted_s = (ext_s + RND) >>> OUT_SHIFT;
    if (shifted_s > SAT_MAX) begin
      y = SAT_MAX[OUT_WIDTH-1:0];
    end else if (shifted_s < SAT_MIN) begin
      y = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      y = shifted_s[OUT_WIDTH-1:0];
    end
  end
`else
  // Truncating scale: keep the low bits, two's-complement wrap.
  always_comb begin
    ext_s     = {acc_r[ACC_WIDTH-1], acc_r};
    shifted_s = ext_s >>> OUT_SHIFT;
    y         = shifted_s[OUT_WIDTH-1:0];
  end
`endif

endmodule

// File: rtl/fir_filter_mac.sv
// Time-multiplexed signed FIR: one MAC shared across TAP_COUNT taps, valid/ready on both sides.
// Optional rounding/saturation in the output stage is enabled by FIR_ROUND_SAT_EN.
module fir_filter_mac
  import fir_pkg::*;
#(
  parameter int TAP_COUNT   = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int OUT_SHIFT   = 6,
  parameter logic [TAP_COUNT*COEFF_WIDTH-1:0] COEFF_INIT = {8'sd48, 8'sd47, 8'sd13, 8'sd17}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         x_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          y_out,
  input  logic                          coef_we,
  input  logic [clog2(TAP_COUNT)-1:0]   coef_addr,
  input  logic [COEFF_WIDTH-1:0]        coef_data,
  output logic                          coef_err
);

  localparam int AW        = clog2(TAP_COUNT);
  localparam int IW        = AW + 1;
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COEFF_WIDTH, TAP_COUNT);
  localparam logic [IW-1:0] LAST_IDX = IW'(TAP_COUNT);

  state_e                 state_r, state_s;
  logic [IW-1:0]          idx_r;
  logic [DATA_WIDTH-1:0]  x_r     [TAP_COUNT];
  logic [COEFF_WIDTH-1:0] coeff_r [TAP_COUNT];
  logic                   accept_s, mac_en_s, finish_s, coef_ok_s;
  logic [OUT_WIDTH-1:0]   y_s;

  // idx runs one step past the last tap so the scaled result is taken from a settled accumulator.
  always_comb begin
    accept_s  = (state_r == ST_IDLE) && in_valid;
    mac_en_s  = (state_r == ST_MAC) && (idx_r != LAST_IDX);
    finish_s  = (state_r == ST_MAC) && (idx_r == LAST_IDX);
    coef_ok_s = coef_we && (state_r == ST_IDLE) && ({1'b0, coef_addr} < LAST_IDX);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: state_s = in_valid ? ST_MAC : ST_IDLE;
      ST_MAC:  state_s = finish_s ? ST_OUT : ST_MAC;
      ST_OUT:  state_s = out_ready ? ST_IDLE : ST_OUT;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      ST_IDLE: in_ready  = 1'b1;
      ST_OUT:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Delay line, tap index, coefficient file, result and write-error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r    <= '0;
      y_out    <= '0;
      coef_err <= 1'b0;
      for (int k = 0; k < TAP_COUNT; k++) begin
        x_r[k]     <= '0;
        coeff_r[k] <= COEFF_INIT[k*COEFF_WIDTH +: COEFF_WIDTH];
      end
    end else begin
      coef_err <= coef_we && !coef_ok_s;
      if (coef_ok_s) begin
        coeff_r[coef_addr] <= coef_data;
      end
      if (accept_s) begin
        x_r[0] <= x_in;
        for (int k = 1; k < TAP_COUNT; k++) begin
          x_r[k] <= x_r[k-1];
        end
        idx_r <= '0;
      end else if (mac_en_s) begin
        idx_r <= idx_r + IW'(1);
      end
      if (finish_s) begin
        y_out <= y_s;
      end
    end
  end

  fir_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEFF_WIDTH(COEFF_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .OUT_SHIFT  (OUT_SHIFT)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(accept_s),
    .en (mac_en_s),
    .x  (x_r[idx_r[AW-1:0]]),
    .c  (coeff_r[idx_r[AW-1:0]]),
    .y  (y_s)
  );

endmodule

// File: tb/tb_fir_filter_mac.sv
// Directed and random checks of fir_filter_mac against an arithmetic FIR model.
// Two instances share stimulus: OUT_SHIFT=0 and OUT_SHIFT=1.
module tb_fir_filter_mac;

  logic       clk, rst, in_valid, out_ready, coef_we;
  logic [7:0] x_in, coef_data;
  logic [1:0] coef_addr;
  logic       in_ready, out_valid, coef_err;
  logic       in_ready_r, out_valid_r, coef_err_r;
  logic [7:0] y_out, y_rnd;

  int tests = 0;
  int fails = 0;
  int lat;
  int hist[4];
  int cf[4];
  int exp_acc;

  fir_filter_mac #(.OUT_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err)
  );

  fir_filter_mac #(.OUT_SHIFT(1)) dut_rnd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .x_in(x_in),
    .out_valid(out_valid_r), .out_ready(out_ready), .y_out(y_rnd),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int post(input int acc, input int sh);
    int r;
    logic [7:0] t;
`ifdef FIR_ROUND_SAT_EN
    r = (sh > 0) ? ((acc + (1 << (sh - 1))) >>> sh) : acc;
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
    t = r[7:0];
`else
    r = acc >>> sh;
    t = r[7:0];
`endif
    return int'($signed(t));
  endfunction

  function automatic void model_reset();
    hist = '{0, 0, 0, 0};
    cf   = '{17, 13, 47, 48};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    lat++;
  endtask

  task automatic accept(input logic [7:0] x, input logic we, input logic [1:0] addr, input logic [7:0] data);
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    x_in      = x;
    coef_we   = we;
    coef_addr = addr;
    coef_data = data;
    if (we) cf[addr] = int'($signed(data));
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'($signed(x));
    exp_acc = 0;
    for (int k = 0; k < 4; k++) exp_acc += hist[k] * cf[k];
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    lat      = 0;
    if (we) chk("coef_err_idle_write", coef_err, 0);
  endtask

  task automatic wait_out();
    while (!out_valid && lat < 20) step();
    chk("latency", lat, 5);
    chk("y_out", $signed(y_out), post(exp_acc, 0));
    chk("y_out_shift1", $signed(y_rnd), post(exp_acc, 1));
    chk("out_valid_shift1", out_valid_r, 1);
    chk("in_ready_busy", in_ready, 0);
  endtask

  task automatic release_out(input int hold);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_y_out", $signed(y_out), post(exp_acc, 0));
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_take", out_valid, 0);
    chk("in_ready_after_take", in_ready, 1);
    chk("in_ready_after_take_shift1", in_ready_r, 1);
  endtask

  task automatic xact(input logic [7:0] x, input int hold);
    accept(x, 1'b0, 2'd0, 8'd0);
    wait_out();
    release_out(hold);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; coef_we = 1'b0;
    x_in = 8'd0; coef_addr = 2'd0; coef_data = 8'd0;
    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y_out", $signed(y_out), 0);
    chk("rst_coef_err", coef_err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);

    // Impulse response, then saturation / wrap with full-scale input.
    xact(8'd1, 0);
    for (int i = 0; i < 4; i++) xact(8'd0, 0);
    for (int i = 0; i < 4; i++) xact(8'd127, 0);

    // Backpressure for ten cycles.
    xact(8'hFD, 10);

    // Coefficient write in IDLE, then impulse over a flushed line.
    for (int i = 0; i < 3; i++) xact(8'd0, 0);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'hFB;
    cf[0] = -5;
    @(posedge clk);
    @(negedge clk);
    coef_we = 1'b0;
    chk("coef_err_idle", coef_err, 0);
    xact(8'd1, 0);

    // Write coincident with the sample is used by that sample.
    accept(8'd2, 1'b1, 2'd3, 8'd100);
    wait_out();
    release_out(1);

    // Write during MAC is dropped and flagged for one cycle.
    accept(8'd0, 1'b0, 2'd0, 8'd0);
    coef_we = 1'b1; coef_addr = 2'd1; coef_data = 8'd99;
    step();
    coef_we = 1'b0;
    chk("coef_err_mac", coef_err, 1);
    chk("coef_err_mac_shift1", coef_err_r, 1);
    step();
    chk("coef_err_pulse_end", coef_err, 0);
    wait_out();
    release_out(0);
    xact(8'd0, 0);
    xact(8'd0, 0);

    // Reset in the middle of MAC.
    accept(8'd5, 1'b0, 2'd0, 8'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_y_out", $signed(y_out), 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    xact(8'd1, 0);

    // Random samples, random IDLE writes, random backpressure.
    for (int i = 0; i < 40; i++) begin
      accept(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      wait_out();
      release_out(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
